// File: rtl/fpa_pkg.sv
// fpa_pkg: shared types and constants for the binary32 add/sub alignment stage.
package fpa_pkg;
    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = 24;
    localparam int ALN_W = 27;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN_DEFAULT = 32'hFFC00000;
    typedef struct packed {
        logic [31:0]      raw;
        fp_class_t        cls;
        logic             hid;
        logic [EXP_W-1:0] eexp;
    } opnd_t;
    typedef struct packed {
        logic             sign_l;
        logic             sign_s;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] mant_l;
        logic [ALN_W-1:0] mant_s;
        logic             eff_sub;
        logic             special;
        logic [31:0]      word;
    } aligned_t;
endpackage

// File: rtl/fpa_classify.sv
// fpa_classify: classifies one binary32 operand and derives hidden bit and effective exponent.
module fpa_classify
    import fpa_pkg::*;
(
    input  logic [31:0]      x_i,
    output fp_class_t        cls_o,
    output logic             hid_o,
    output logic [EXP_W-1:0] eexp_o
);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    assign e = x_i[30:23];
    assign m = x_i[22:0];
    assign cls_o = (e == '0) ? ((m == '0) ? ZERO : SUB) :
                   (e == EXP_MAX) ? ((m == '0) ? INF : NAN) : NORM;
    assign hid_o = (e != '0);
    // Subnormals and zero share the exponent of the smallest normal.
    assign eexp_o = (e == '0) ? 8'd1 : e;
endmodule

// File: rtl/fpa_align.sv
// fpa_align: two-stage operand classify/compare/swap/align front end of a binary32 adder.
module fpa_align
    import fpa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] number_A,
    input  logic [31:0] number_B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign_l,
    output logic        out_sign_s,
    output logic [7:0]  out_exp,
    output logic [23:0] out_mant_l,
    output logic [26:0] out_mant_s,
    output logic        out_eff_sub,
    output logic        out_special,
    output logic [31:0] out_special_word
);
    opnd_t a_d, b_d, a_q, b_q, l, s;
    aligned_t al_d, al_q;
    logic s1_v_q, s2_v_q, s2_adv, a_lg;
    logic [EXP_W-1:0] d;
    logic [SIG_W-1:0] sig_s;
    logic [ALN_W-1:0] ext, sh, mask;
    logic a_nan, b_nan, a_inf, b_inf;

    fpa_classify u_cls_a (.x_i(number_A), .cls_o(a_d.cls), .hid_o(a_d.hid), .eexp_o(a_d.eexp));
    fpa_classify u_cls_b (.x_i(number_B), .cls_o(b_d.cls), .hid_o(b_d.hid), .eexp_o(b_d.eexp));
    assign a_d.raw = number_A;
    assign b_d.raw = number_B;

    assign s2_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_adv;

    // Ties on magnitude keep A as the larger operand.
    assign a_lg  = a_q.raw[30:0] >= b_q.raw[30:0];
    assign l     = a_lg ? a_q : b_q;
    assign s     = a_lg ? b_q : a_q;
    assign d     = l.eexp - s.eexp;
    assign sig_s = {s.hid, s.raw[22:0]};
    assign ext   = {sig_s, 3'b000};
    assign sh    = ext >> d;
    assign mask  = (27'd1 << d) - 27'd1;

    assign a_nan = a_q.cls == NAN;
    assign b_nan = b_q.cls == NAN;
    assign a_inf = a_q.cls == INF;
    assign b_inf = b_q.cls == INF;

    always_comb begin
        al_d.sign_l  = l.raw[31];
        al_d.sign_s  = s.raw[31];
        al_d.exp     = l.eexp;
        al_d.mant_l  = {l.hid, l.raw[22:0]};
        // Bit 0 of the shifted word sits below R, so it folds into sticky.
        al_d.mant_s  = (d >= 8'd27) ? {26'd0, |sig_s} : {sh[26:1], sh[0] | (|(ext & mask))};
        al_d.eff_sub = l.raw[31] ^ s.raw[31];
        al_d.special = a_nan || b_nan || a_inf || b_inf;
        al_d.word    = a_nan ? (a_q.raw | 32'h0040_0000) :
                       b_nan ? (b_q.raw | 32'h0040_0000) :
                       (a_inf && b_inf && (a_q.raw[31] != b_q.raw[31])) ? QNAN_DEFAULT :
                       a_inf ? a_q.raw :
                       b_inf ? b_q.raw : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            al_q   <= '0;
        end else begin
            if (in_ready) begin
                s1_v_q <= in_valid;
                if (in_valid) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) al_q <= al_d;
            end
        end
    end

    assign out_valid        = s2_v_q;
    assign out_sign_l       = al_q.sign_l;
    assign out_sign_s       = al_q.sign_s;
    assign out_exp          = al_q.exp;
    assign out_mant_l       = al_q.mant_l;
    assign out_mant_s       = al_q.mant_s;
    assign out_eff_sub      = al_q.eff_sub;
    assign out_special      = al_q.special;
    assign out_special_word = al_q.word;
endmodule

// File: doc/fpa_align.md
FPA_ALIGN -- requirements
Module: fpa_align

Interface
REQ-001 Parameter: none; format fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  stage accepts pair this cycle.
REQ-006 number_A, number_B  input  32 each  raw binary32 operands.
REQ-007 out_valid  output  1  aligned pair present for the adder stage.
REQ-008 out_ready  input  1  adder stage accepts this cycle.
REQ-009 out_sign_l, out_sign_s  output  1 each  signs of larger- and smaller-magnitude operand.
REQ-010 out_exp  output  8  effective exponent of larger operand (subnormal/zero reads 1).
REQ-011 out_mant_l  output  24  larger significand, hidden bit included.
REQ-012 out_mant_s  output  27  smaller significand aligned to out_mant_l, {24 bits, G, R, S}.
REQ-013 out_eff_sub  output  1  out_sign_l != out_sign_s.
REQ-014 out_special  output  1  result fully decided here (NaN/Inf).
REQ-015 out_special_word  output  32  final result when out_special=1, else 0.

Function
REQ-016 Two-register pipeline: S1 captures operands and classifies; S2 compares, swaps, shifts.
REQ-017 Latency 2 cycles from accepted in_valid to out_valid with out_ready held 1; throughput one pair per cycle.
REQ-018 Transfer occurs on valid&ready at each boundary; in_ready = !S1_valid | (S1 advancing); S1 advances when !S2_valid | out_ready.
REQ-019 While out_valid=1 and out_ready=0, all out_* held stable; no pair dropped or duplicated.
REQ-020 Class per operand: ZERO (exp 0, mant 0), SUB (exp 0, mant!=0), NORM, INF (exp FF, mant 0), NAN (exp FF, mant!=0).
REQ-021 Larger = greater {exp,mant} 31-bit magnitude; equal magnitude -> A is larger.
REQ-022 Shift d = eff_exp_l - eff_exp_s; hidden bit = (exp!=0).
REQ-023 out_mant_s = small significand right-shifted by d with G,R and S = OR of all bits shifted past R.
REQ-024 d >= 27: out_mant_s upper 26 bits 0, S = (small significand != 0).
REQ-025 Special priority: A NaN -> A with bit22 set; else B NaN -> B with bit22 set; else INF+opposite-sign INF -> 32'hFFC00000; else any INF -> that INF.
REQ-026 When out_special=1, non-special outputs still computed normally (don't-care for consumer).
REQ-027 ZERO operands pass through normally (both signs preserved for the adder's signed-zero rule).

Reset
REQ-028 rst_n low: S1_valid, S2_valid, out_valid -> 0 immediately; in_ready -> 1 after release; all data outputs -> 0.
REQ-029 Reset mid-stream discards in-flight pairs; first accepted pair after release emerges after 2 cycles.

Structure
REQ-030 Package fpa_pkg: fp_class_t enum (ZERO,SUB,NORM,INF,NAN), field widths, EXP_MAX=8'hFF, QNAN_DEFAULT=32'hFFC00000.
REQ-031 Sub-module fpa_classify (combinational, one operand -> class, hidden bit, effective exponent), instantiated twice.

Verification
REQ-032 A=3F800000(1.0), B=40000000(2.0), out_ready=1 -> 2 cycles later: sign_l=0, exp=80, mant_l=800000, mant_s=0x2000000 (1.0 shifted 1), eff_sub=0.
REQ-033 A=00000001, B=7F7FFFFF -> larger=B, d=253, out_mant_s=0x0000001 (sticky only), special=0.
REQ-034 A=7F800000, B=FF800000 -> special=1, word=FFC00000; A=7F800001, B=7FC00005 -> word=7FC00001.
REQ-035 Back-to-back pairs, out_ready toggled 1,0,0,1 -> outputs held during stall, order preserved, in_ready=0 once both stages full.
REQ-036 rst_n pulsed low with 2 pairs in flight -> out_valid=0 same cycle, no stale pair appears after release.
REQ-037 Equal magnitudes A=C0400000, B=40400000 -> larger=A, sign_l=1, sign_s=0, eff_sub=1, out_mant_s={C00000,3'b000}.
